// File: rtl/moldudp64_seq_ctrl.sv
// MoldUDP64 sequence-number controller: locks onto one session, classifies each header as
// accept/skip/drop and drives a retransmission request with timeout and bounded retry.
module moldudp64_seq_ctrl #(
  parameter int              SID_W     = 80,
  parameter int              SEQ_W     = 64,
  parameter int              ML_W      = 16,
  parameter logic [ML_W-1:0] RTX_MAX   = 16'd64,
  parameter int              TO_CYC    = 1024,
  parameter int              MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             hdr_v_i,
  input  logic [SID_W-1:0] hdr_sid_i,
  input  logic [SEQ_W-1:0] hdr_seq_i,
  input  logic [ML_W-1:0]  hdr_cnt_i,
  output logic             dec_v_o,
  output logic             dec_acc_o,
  output logic [ML_W-1:0]  dec_skip_o,
  output logic             rtx_v_o,
  input  logic             rtx_ready_i,
  output logic [SEQ_W-1:0] rtx_seq_o,
  output logic [ML_W-1:0]  rtx_cnt_o,
  output logic             gap_lost_o,
  output logic             sess_end_o,
  output logic [SEQ_W-1:0] exp_seq_o
);

  localparam int TMR_W = $clog2(TO_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_RTX_REQ  = 3'd2,
    ST_RTX_WAIT = 3'd3,
    ST_END      = 3'd4
  } state_t;

  state_t             state_r;
  logic [SID_W-1:0]   sid_r;
  logic [SEQ_W-1:0]   exp_seq_r;
  logic [SEQ_W-1:0]   rtx_seq_r;
  logic [ML_W-1:0]    rtx_cnt_r;
  logic [RTY_W-1:0]   retry_r;
  logic [TMR_W-1:0]   timer_r;
  logic               dec_v_r;
  logic               dec_acc_r;
  logic [ML_W-1:0]    dec_skip_r;
  logic               rtx_v_r;
  logic               gap_lost_r;
  logic               sess_end_r;

  logic [ML_W-1:0]    eff_cnt_s;
  logic [SEQ_W-1:0]   sum_s;
  logic [SEQ_W-1:0]   gap_s;
  logic [SEQ_W-1:0]   rtx_end_s;
  logic [ML_W-1:0]    skip_s;
  logic [ML_W-1:0]    rtx_len_s;
  logic               sid_ok_s;
  logic               eos_s;
  logic               hb_s;
  logic               gap_det_s;
  logic               in_order_s;

  function automatic logic [ML_W-1:0] clamp_len(input logic [SEQ_W-1:0] len);
    if (len > SEQ_W'(RTX_MAX)) begin
      clamp_len = RTX_MAX;
    end else begin
      clamp_len = len[ML_W-1:0];
    end
  endfunction

  // Header classification against the expected sequence number
  always_comb begin
    // an end-of-session marker that is not exactly in order behaves like a heartbeat at its seq
    if (hdr_cnt_i == {ML_W{1'b1}}) begin
      eff_cnt_s = {ML_W{1'b0}};
    end else begin
      eff_cnt_s = hdr_cnt_i;
    end
    sum_s      = hdr_seq_i + SEQ_W'(eff_cnt_s);
    gap_s      = hdr_seq_i - exp_seq_r;
    skip_s     = ML_W'(exp_seq_r - hdr_seq_i);
    rtx_len_s  = clamp_len(gap_s);
    rtx_end_s  = rtx_seq_r + SEQ_W'(rtx_cnt_r);
    sid_ok_s   = (hdr_sid_i == sid_r);
    eos_s      = (hdr_cnt_i == {ML_W{1'b1}}) && (hdr_seq_i == exp_seq_r);
    hb_s       = (eff_cnt_s == {ML_W{1'b0}}) && (hdr_seq_i == exp_seq_r);
    gap_det_s  = (hdr_seq_i > exp_seq_r);
    in_order_s = (hdr_seq_i <= exp_seq_r) && (exp_seq_r < sum_s);
  end

  // Session FSM with registered decision and request outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= ST_IDLE;
      sid_r      <= {SID_W{1'b0}};
      exp_seq_r  <= {SEQ_W{1'b0}};
      rtx_seq_r  <= {SEQ_W{1'b0}};
      rtx_cnt_r  <= {ML_W{1'b0}};
      retry_r    <= {RTY_W{1'b0}};
      timer_r    <= {TMR_W{1'b0}};
      dec_v_r    <= 1'b0;
      dec_acc_r  <= 1'b0;
      dec_skip_r <= {ML_W{1'b0}};
      rtx_v_r    <= 1'b0;
      gap_lost_r <= 1'b0;
      sess_end_r <= 1'b0;
    end else begin
      dec_v_r    <= hdr_v_i;
      dec_acc_r  <= 1'b0;
      dec_skip_r <= {ML_W{1'b0}};
      gap_lost_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (hdr_v_i) begin
            sid_r     <= hdr_sid_i;
            exp_seq_r <= sum_s;
            dec_acc_r <= 1'b1;
            if (hdr_cnt_i == {ML_W{1'b1}}) begin
              sess_end_r <= 1'b1;
              state_r    <= ST_END;
            end else begin
              state_r <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (hdr_v_i && sid_ok_s) begin
            if (eos_s) begin
              dec_acc_r  <= 1'b1;
              sess_end_r <= 1'b1;
              state_r    <= ST_END;
            end else if (hb_s) begin
              dec_acc_r <= 1'b1;
            end else if (gap_det_s) begin
              rtx_seq_r <= exp_seq_r;
              rtx_cnt_r <= rtx_len_s;
              retry_r   <= {RTY_W{1'b0}};
              rtx_v_r   <= 1'b1;
              state_r   <= ST_RTX_REQ;
            end else if (in_order_s) begin
              dec_acc_r  <= 1'b1;
              dec_skip_r <= skip_s;
              exp_seq_r  <= sum_s;
            end
          end
        end
        ST_RTX_REQ: begin
          // an in-order header beats a same-cycle handshake and withdraws the request
          if (hdr_v_i && sid_ok_s && in_order_s) begin
            dec_acc_r  <= 1'b1;
            dec_skip_r <= skip_s;
            exp_seq_r  <= sum_s;
            rtx_v_r    <= 1'b0;
            state_r    <= ST_SYNC;
          end else if (rtx_v_r && rtx_ready_i) begin
            rtx_v_r <= 1'b0;
            timer_r <= {TMR_W{1'b0}};
            state_r <= ST_RTX_WAIT;
          end
        end
        ST_RTX_WAIT: begin
          if (hdr_v_i && sid_ok_s && in_order_s) begin
            dec_acc_r  <= 1'b1;
            dec_skip_r <= skip_s;
            exp_seq_r  <= sum_s;
            state_r    <= ST_SYNC;
          end else if (timer_r == TMR_W'(TO_CYC)) begin
            if (retry_r < RTY_W'(MAX_RETRY)) begin
              retry_r <= retry_r + {{(RTY_W-1){1'b0}}, 1'b1};
              rtx_v_r <= 1'b1;
              state_r <= ST_RTX_REQ;
            end else begin
              gap_lost_r <= 1'b1;
              exp_seq_r  <= rtx_end_s;
              state_r    <= ST_SYNC;
            end
          end else begin
            timer_r <= timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
          end
        end
        ST_END: begin
          state_r <= ST_END;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dec_v_o    = dec_v_r;
  assign dec_acc_o  = dec_acc_r;
  assign dec_skip_o = dec_skip_r;
  assign rtx_v_o    = rtx_v_r;
  assign rtx_seq_o  = rtx_seq_r;
  assign rtx_cnt_o  = rtx_cnt_r;
  assign gap_lost_o = gap_lost_r;
  assign sess_end_o = sess_end_r;
  assign exp_seq_o  = exp_seq_r;

endmodule

// File: tb/tb_moldudp64_seq_ctrl.sv
// Directed bench for moldudp64_seq_ctrl: session lock, duplicates, gap request/retry/loss,
// request withdrawal, end of session and asynchronous reset during a request.
module tb_moldudp64_seq_ctrl;

  localparam logic [63:0] B     = 64'hF0F0_F0F0_F0F0_F0F0;
  localparam logic [79:0] SID_A = 80'hDEADBEEF;
  localparam logic [79:0] SID_B = 80'hCAFE;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        hdr_v_i = 1'b0;
  logic [79:0] hdr_sid_i = 80'd0;
  logic [63:0] hdr_seq_i = 64'd0;
  logic [15:0] hdr_cnt_i = 16'd0;
  logic        dec_v_o, dec_acc_o, rtx_v_o, gap_lost_o, sess_end_o;
  logic [15:0] dec_skip_o, rtx_cnt_o;
  logic [63:0] rtx_seq_o, exp_seq_o;
  logic        rtx_ready_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  moldudp64_seq_ctrl dut (
    .clk(clk), .nreset(nreset),
    .hdr_v_i(hdr_v_i), .hdr_sid_i(hdr_sid_i), .hdr_seq_i(hdr_seq_i), .hdr_cnt_i(hdr_cnt_i),
    .dec_v_o(dec_v_o), .dec_acc_o(dec_acc_o), .dec_skip_o(dec_skip_o),
    .rtx_v_o(rtx_v_o), .rtx_ready_i(rtx_ready_i), .rtx_seq_o(rtx_seq_o), .rtx_cnt_o(rtx_cnt_o),
    .gap_lost_o(gap_lost_o), .sess_end_o(sess_end_o), .exp_seq_o(exp_seq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // one-cycle header pulse; returns on the falling edge after the decision edge
  task automatic send(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    @(negedge clk);
    hdr_v_i = 1'b1; hdr_sid_i = sid; hdr_seq_i = seq; hdr_cnt_i = cnt;
    @(negedge clk);
    hdr_v_i = 1'b0;
  endtask

  task automatic expect_dec(input string tag, input logic acc, input logic [15:0] skip,
                            input logic [63:0] exp_seq);
    check({tag, "_v"}, 64'(dec_v_o), 64'd1);
    check({tag, "_acc"}, 64'(dec_acc_o), 64'(acc));
    check({tag, "_skip"}, 64'(dec_skip_o), 64'(skip));
    check({tag, "_exp"}, exp_seq_o, exp_seq);
  endtask

  initial begin
    int rereq;
    bit lost;
    int cyc;

    #12;
    check("rst_dec_v", 64'(dec_v_o), 64'd0);
    check("rst_rtx_v", 64'(rtx_v_o), 64'd0);
    check("rst_exp", exp_seq_o, 64'd0);
    check("rst_sess_end", 64'(sess_end_o), 64'd0);
    @(negedge clk);
    nreset = 1'b1;

    // lock and in-order traffic
    send(SID_A, B, 16'd3);
    expect_dec("lock", 1'b1, 16'd0, B + 64'd3);
    @(negedge clk);
    check("dec_v_pulse", 64'(dec_v_o), 64'd0);
    send(SID_A, B + 64'd3, 16'd2);
    expect_dec("inord", 1'b1, 16'd0, B + 64'd5);
    send(SID_A, B + 64'd2, 16'd2);
    expect_dec("stale", 1'b0, 16'd0, B + 64'd5);
    send(SID_A, B + 64'd5, 16'd0);
    expect_dec("hb", 1'b1, 16'd0, B + 64'd5);

    // gap: request held while the consumer is not ready
    send(SID_A, B + 64'd10, 16'd1);
    expect_dec("gap", 1'b0, 16'd0, B + 64'd5);
    for (int i = 0; i < 3; i++) begin
      check("hold_v", 64'(rtx_v_o), 64'd1);
      check("hold_seq", rtx_seq_o, B + 64'd5);
      check("hold_cnt", 64'(rtx_cnt_o), 64'd5);
      @(negedge clk);
    end
    rtx_ready_i = 1'b1;
    @(negedge clk);
    rtx_ready_i = 1'b0;
    check("hs_drop", 64'(rtx_v_o), 64'd0);

    // no fill: three re-requests, then the gap is abandoned
    rereq = 0; lost = 1'b0; cyc = 0;
    while (!lost && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (gap_lost_o) begin
        lost = 1'b1;
      end else if (rtx_v_o) begin
        rereq++;
        check("rereq_seq", rtx_seq_o, B + 64'd5);
        rtx_ready_i = 1'b1;
        @(negedge clk);
        rtx_ready_i = 1'b0;
        cyc++;
      end
    end
    check("rereq_count", 64'(rereq), 64'd3);
    check("gap_lost_seen", 64'(lost), 64'd1);
    check("exp_after_lost", exp_seq_o, B + 64'd10);
    @(negedge clk);
    check("gap_lost_pulse", 64'(gap_lost_o), 64'd0);

    // overlap with already-consumed messages
    send(SID_A, B + 64'd9, 16'd3);
    expect_dec("overlap", 1'b1, 16'd1, B + 64'd12);

    // large gap clamps the request; in-order header withdraws it
    send(SID_A, B + 64'd112, 16'd1);
    expect_dec("gap2", 1'b0, 16'd0, B + 64'd12);
    check("clamp_cnt", 64'(rtx_cnt_o), 64'd64);
    check("clamp_seq", rtx_seq_o, B + 64'd12);
    send(SID_A, B + 64'd12, 16'd4);
    expect_dec("fill", 1'b1, 16'd0, B + 64'd16);
    check("withdraw", 64'(rtx_v_o), 64'd0);

    // foreign session, end of session, then everything dropped
    send(SID_B, B + 64'd16, 16'd1);
    expect_dec("foreign", 1'b0, 16'd0, B + 64'd16);
    send(SID_A, B + 64'd16, 16'hFFFF);
    expect_dec("eos", 1'b1, 16'd0, B + 64'd16);
    check("sess_end", 64'(sess_end_o), 64'd1);
    send(SID_A, B + 64'd16, 16'd1);
    expect_dec("after_end", 1'b0, 16'd0, B + 64'd16);
    check("sess_end_sticky", 64'(sess_end_o), 64'd1);

    // reset while a request is pending
    @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    send(SID_A, 64'd100, 16'd2);
    send(SID_A, 64'd110, 16'd1);
    check("pre_rst_rtx_v", 64'(rtx_v_o), 64'd1);
    #2;
    nreset = 1'b0;
    #1;
    check("async_rtx_v", 64'(rtx_v_o), 64'd0);
    check("async_exp", exp_seq_o, 64'd0);
    check("async_sess_end", 64'(sess_end_o), 64'd0);
    check("async_rtx_seq", rtx_seq_o, 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    send(SID_B, 64'd500, 16'd4);
    expect_dec("relock", 1'b1, 16'd0, 64'd504);
    send(SID_A, 64'd504, 16'd1);
    expect_dec("old_sid", 1'b0, 16'd0, 64'd504);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
